alu_sequencer: RTL

Command-level controller in front of the 2-bit-serial `ALU`. It accepts one decoded command per handshake and drives every `ALU` control input for the command's duration. It serialises 8/16-bit immediates onto `data_in2` and, optionally, deserialises register reads from `data_out` into a parallel response word. It allows back-to-back commands with no idle cycle between them.

---
 rtl/alu_sequencer_if.sv | 32 +++
 rtl/alu_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command/response bus of alu_sequencer.
// master = command issuer, slave = the sequencer.
`ifndef OP_BITS
`define OP_BITS 4
`endif

interface alu_sequencer_if #(
  parameter int LOG2_NR = 3,
  parameter int OP_BITS = `OP_BITS
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_kind;
  logic [OP_BITS-1:0] cmd_op;
  logic [LOG2_NR-1:0] cmd_r1;
  logic [LOG2_NR-1:0] cmd_r2;
  logic               cmd_pair;
  logic [15:0]        cmd_imm;
  logic               busy;
  logic               rsp_valid;
  logic [15:0]        rsp_data;

  modport master (
    output cmd_valid, cmd_kind, cmd_op, cmd_r1, cmd_r2, cmd_pair, cmd_imm,
    input  cmd_ready, busy, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_op, cmd_r1, cmd_r2, cmd_pair, cmd_imm,
    output cmd_ready, busy, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-level controller in front of the 2-bit-serial ALU.
// Latches one decoded command per handshake and holds every ALU control
// input stable for the command's duration; serialises the immediate onto
// data_in2. Back-to-back commands are accepted on the op_done cycle.
// Optional feature macro: ALU_SEQ_CAPTURE_EN (deserialise READ results
// from alu_data_out into rsp_data / rsp_valid).
`ifndef OP_BITS
`define OP_BITS 4
`endif
`ifndef OP_ADD
`define OP_ADD 0
`endif
`ifndef OP_ADC
`define OP_ADC 1
`endif
`ifndef OP_SUB
`define OP_SUB 2
`endif
`ifndef OP_SBC
`define OP_SBC 3
`endif
`ifndef OP_MOV
`define OP_MOV 7
`endif

module alu_sequencer #(
  parameter  int LOG2_NR = 3,
  parameter  int OP_BITS = `OP_BITS,
  localparam int RC      = $clog2(16/2)
) (
  input  logic               clk,
  input  logic               reset,
  alu_sequencer_if.slave     cmd,
  output logic               alu_op_valid,
  output logic [OP_BITS-1:0] alu_operation,
  output logic               alu_external_arg1,
  output logic               alu_external_arg2,
  output logic               alu_pair_op,
  output logic               alu_pair_op2,
  output logic               alu_sext2,
  output logic               alu_arg2_limit_length,
  output logic [LOG2_NR-1:0] alu_reg1,
  output logic [LOG2_NR-1:0] alu_reg2,
  output logic               alu_update_reg1,
  output logic               alu_reverse_args,
  output logic               alu_double_arg2,
  output logic               alu_output_scan_out,
  output logic               alu_update_carry_flags,
  output logic               alu_update_other_flags,
  output logic               alu_rotate,
  output logic               alu_do_shr,
  output logic [RC-1:0]      alu_rotate_count,
  output logic               alu_do_swap_reg,
  output logic               alu_do_swap_mem,
  output logic [1:0]         alu_data_in2,
  output logic [1:0]         alu_data_in1,
  input  logic               alu_op_done,
  input  logic [1:0]         alu_data_out
);

  localparam logic [OP_BITS-1:0] OP_ADD_C = OP_BITS'(`OP_ADD);
  localparam logic [OP_BITS-1:0] OP_ADC_C = OP_BITS'(`OP_ADC);
  localparam logic [OP_BITS-1:0] OP_SUB_C = OP_BITS'(`OP_SUB);
  localparam logic [OP_BITS-1:0] OP_SBC_C = OP_BITS'(`OP_SBC);
  localparam logic [OP_BITS-1:0] OP_MOV_C = OP_BITS'(`OP_MOV);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [2:0] {
    K_RR, K_RI, K_RR_NOWB, K_RI_NOWB, K_ROT, K_SHR, K_SWAP, K_READ
  } kind_t;

  typedef struct packed {
    logic               op_valid;
    logic [OP_BITS-1:0] operation;
    logic               ext2;
    logic               pair;
    logic [LOG2_NR-1:0] reg1;
    logic [LOG2_NR-1:0] reg2;
    logic               upd1;
    logic               carry;
    logic               other;
    logic               rotate;
    logic               shr;
    logic [RC-1:0]      rc;
    logic               swap;
    logic               scan;
  } ctl_t;

  state_t      state;
  ctl_t        ctl_q;
  ctl_t        ctl_d;
  logic [15:0] imm_sr;
  logic        accept;
  kind_t       kind;

  assign kind      = kind_t'(cmd.cmd_kind);
  assign cmd.cmd_ready = (state == IDLE) || alu_op_done;
  assign accept    = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd.busy  = (state == RUN);

  // Decode the offered command into the full ALU control word.
  always_comb begin
    ctl_d          = '0;
    ctl_d.op_valid = 1'b1;
    ctl_d.pair     = cmd.cmd_pair;
    ctl_d.reg1     = cmd.cmd_r1;
    ctl_d.reg2     = cmd.cmd_r2;
    unique case (kind)
      K_RR, K_RI, K_RR_NOWB, K_RI_NOWB: begin
        ctl_d.operation = cmd.cmd_op;
        ctl_d.other     = 1'b1;
        ctl_d.carry     = (cmd.cmd_op == OP_ADD_C) || (cmd.cmd_op == OP_SUB_C) ||
                          (cmd.cmd_op == OP_ADC_C) || (cmd.cmd_op == OP_SBC_C);
        ctl_d.upd1      = (kind == K_RR) || (kind == K_RI);
        ctl_d.ext2      = (kind == K_RI) || (kind == K_RI_NOWB);
      end
      K_ROT, K_SHR: begin
        ctl_d.rotate = 1'b1;
        ctl_d.shr    = (kind == K_SHR);
        ctl_d.rc     = cmd.cmd_imm[RC-1:0];
      end
      K_SWAP: begin
        ctl_d.operation = OP_MOV_C;
        ctl_d.swap      = 1'b1;
        ctl_d.upd1      = 1'b1;
      end
      K_READ: begin
        ctl_d.scan = 1'b1;
      end
    endcase
  end

  // Command FSM: latch decoded controls on accept, clear them on return to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ctl_q  <= '0;
      imm_sr <= '0;
    end else begin
      if (state == RUN) imm_sr <= {2'b00, imm_sr[15:2]};
      if (accept) begin
        state  <= RUN;
        ctl_q  <= ctl_d;
        imm_sr <= cmd.cmd_imm;
      end else if (state == RUN && alu_op_done) begin
        state <= IDLE;
        ctl_q <= '0;
      end
    end
  end

  assign alu_op_valid           = ctl_q.op_valid;
  assign alu_operation          = ctl_q.operation;
  assign alu_external_arg2      = ctl_q.ext2;
  assign alu_pair_op            = ctl_q.pair;
  assign alu_pair_op2           = ctl_q.pair;
  assign alu_reg1               = ctl_q.reg1;
  assign alu_reg2               = ctl_q.reg2;
  assign alu_update_reg1        = ctl_q.upd1;
  assign alu_update_carry_flags = ctl_q.carry;
  assign alu_update_other_flags = ctl_q.other;
  assign alu_rotate             = ctl_q.rotate;
  assign alu_do_shr             = ctl_q.shr;
  assign alu_rotate_count       = ctl_q.rc;
  assign alu_do_swap_reg        = ctl_q.swap;
  assign alu_output_scan_out    = ctl_q.scan;
  assign alu_data_in2           = (state == RUN) ? imm_sr[1:0] : 2'b00;
  assign alu_external_arg1      = 1'b0;
  assign alu_data_in1           = 2'b00;
  assign alu_sext2              = 1'b0;
  assign alu_arg2_limit_length  = 1'b0;
  assign alu_reverse_args       = 1'b0;
  assign alu_double_arg2        = 1'b0;
  assign alu_do_swap_mem        = 1'b0;

`ifdef ALU_SEQ_CAPTURE_EN
  logic [15:0] cap;
  logic [15:0] cap_next;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;

  assign cap_next = {alu_data_out, cap[15:2]};

  // Shift the scanned-out register in two bits per cycle; publish at op_done.
  // A single byte ends up in cap_next[15:8] after its four shifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state == RUN && ctl_q.scan) begin
        cap <= cap_next;
        if (alu_op_done) begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= ctl_q.pair ? cap_next : {8'h00, cap_next[15:8]};
        end
      end
    end
  end

  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_data  = rsp_data_q;
`else
  logic unused_data_out;
  assign unused_data_out = ^alu_data_out;
  assign cmd.rsp_valid   = 1'b0;
  assign cmd.rsp_data    = '0;
`endif

endmodule
